// File: rtl/crc_pkg.sv
// Shared definitions for the serial CRC engine family.
// Holds the controller state encoding and the named generator polynomials.
// The single-step LFSR cell and any future parallel engine use the same
// constants, so a polynomial is spelled out in exactly one place.
package crc_pkg;

   // Controller states of the serial engine.
   //    IDLE  : waiting for a word (or a clear request)
   //    SHIFT : feeding the captured word through the LFSR, one bit per clock
   //    DONE  : presenting the finished CRC until the consumer takes it
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } crcState_t;

   // Named generator polynomials, written without the implicit top bit.
   localparam logic [7:0]  CRC8_POLY        = 8'h07;
   localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
   localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;

   // Width of a counter that has to reach (width - 1).
   // A one-bit word still gets a one-bit counter so that no
   // zero-width vector is ever declared.
   function automatic int counterWidth(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/crc_serial_engine_lfsr_step.sv
// One bit-step of a non-reflected CRC LFSR.
// Pure combinational cell: the incoming message bit is XORed with the
// register MSB, and the result decides whether the polynomial is folded
// into the left-shifted register. A parallel engine can chain several of
// these cells back to back.
module lfsr_step #(
   parameter int               CRC_W = 8,
   parameter logic [CRC_W-1:0] POLY  = CRC_W'(8'h07)
) (
   input  logic [CRC_W-1:0] crc_i,
   input  logic             din_i,
   output logic [CRC_W-1:0] crc_o
);

   logic feedback;

   // The feedback bit is the XOR of the outgoing register MSB and the
   // message bit entering at the same time. When it is set, the polynomial
   // is XORed into the shifted register; otherwise the register just
   // shifts left with a zero fill. Only XOR and shift are used, so there
   // are no carries and nothing grows past CRC_W bits.
   always_comb begin
      feedback = crc_i[CRC_W-1] ^ din_i;
      crc_o    = {crc_i[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
   end

endmodule

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine with a programmable polynomial.
// Words arrive over a valid/ready handshake and are shifted MSB-first
// through the LFSR, one bit per clock. After the word flagged "last", the
// finished CRC is presented on a held output handshake. The register
// carries over from word to word until the last word of a message, so
// multi-word frames need no special handling by the source.
module crc_serial_engine
   import crc_pkg::*;
#(
   parameter int               CRC_W   = 8,
   parameter int               DATA_W  = 8,
   parameter logic [CRC_W-1:0] POLY    = CRC_W'(CRC8_POLY),
   parameter logic [CRC_W-1:0] INIT    = '0,
   parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   input  logic              clr,
   output logic [CRC_W-1:0]  crc_out,
   output logic              crc_valid,
   input  logic              crc_ready,
   output logic              busy
);

   // The bit counter counts down from DATA_W-1 to 0, so a SHIFT pass
   // lasts exactly DATA_W cycles.
   localparam int              CNT_W    = counterWidth(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   crcState_t         state_q,    state_d;
   logic [CRC_W-1:0]  crcReg_q,   crcReg_d;
   logic [DATA_W-1:0] shiftReg_q, shiftReg_d;
   logic [CNT_W-1:0]  bitCnt_q,   bitCnt_d;
   logic              lastFlag_q, lastFlag_d;

   // Register value after feeding the current message MSB through the LFSR.
   logic [CRC_W-1:0]  stepCrc;

   // A single LFSR cell: the serial engine consumes one message bit per
   // clock, always the top bit of the captured word.
   lfsr_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY)
   ) u_lfsr_step (
      .crc_i (crcReg_q),
      .din_i (shiftReg_q[DATA_W-1]),
      .crc_o (stepCrc)
   );

   // State and datapath registers. Reset wins over everything, including
   // a message that is half way through SHIFT or waiting in DONE; any
   // partial message is simply dropped and the CRC register is reloaded
   // with the start value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         crcReg_q   <= INIT;
         shiftReg_q <= '0;
         bitCnt_q   <= '0;
         lastFlag_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         crcReg_q   <= crcReg_d;
         shiftReg_q <= shiftReg_d;
         bitCnt_q   <= bitCnt_d;
         lastFlag_q <= lastFlag_d;
      end
   end

   // Next-state and datapath control.
   // IDLE: a clear request has priority over an offered word and blocks
   //    the handshake for that cycle, so a clear between two words aborts
   //    the message cleanly. Otherwise an offered word is captured along
   //    with its "last" flag.
   // SHIFT: one LFSR step per cycle, MSB first. When the final bit goes
   //    in, either wait for the consumer (last word) or go back to IDLE
   //    with the register intact so the next word continues the message.
   // DONE: hold everything until the consumer takes the CRC, then reload
   //    the start value. IDLE is entered on that edge, so the next word is
   //    accepted one cycle later at the earliest.
   always_comb begin
      state_d    = state_q;
      crcReg_d   = crcReg_q;
      shiftReg_d = shiftReg_q;
      bitCnt_d   = bitCnt_q;
      lastFlag_d = lastFlag_q;

      unique case (state_q)
         IDLE: begin
            if (clr) begin
               crcReg_d = INIT;
            end else if (in_valid) begin
               shiftReg_d = in_data;
               lastFlag_d = in_last;
               bitCnt_d   = LAST_BIT;
               state_d    = SHIFT;
            end
         end

         SHIFT: begin
            crcReg_d   = stepCrc;
            shiftReg_d = shiftReg_q << 1;
            if (bitCnt_q == '0) begin
               state_d = lastFlag_q ? DONE : IDLE;
            end else begin
               bitCnt_d = bitCnt_q - CNT_W'(1);
            end
         end

         DONE: begin
            if (crc_ready) begin
               crcReg_d = INIT;
               state_d  = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Handshake and status outputs, decoded straight from the state.
   // in_ready drops while a clear is requested because no word is taken in
   // that cycle. busy covers both SHIFT and DONE.
   always_comb begin
      in_ready  = 1'b0;
      crc_valid = 1'b0;
      busy      = 1'b0;

      unique case (state_q)
         IDLE:    in_ready  = ~clr;
         SHIFT:   busy      = 1'b1;
         DONE: begin
            crc_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            in_ready  = 1'b0;
         end
      endcase
   end

   // The output CRC is a pure function of the register in every state.
   // The register is frozen in DONE, so the value is stable for as long as
   // crc_valid is held, but it only means something while crc_valid is high.
   always_comb begin
      crc_out = crcReg_q ^ XOR_OUT;
   end

endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for the serial CRC engine: a CRC-8 (0x07, init 0) and a CRC-16
// CCITT (0x1021, init FFFF) instance are driven with identical traffic.
// Expected CRCs go into per-instance queues; a monitor pops them when the
// engine presents its result.
module tb_crc_serial_engine;

   logic        clk;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_last;
   logic        clr;
   logic        crc_ready;

   logic        inReady8, crcValid8, busy8;
   logic [7:0]  crcOut8;
   logic        inReady16, crcValid16, busy16;
   logic [15:0] crcOut16;

   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          prevHs = -1;
   int          lastHsNeg = -1000;
   bit          randomReady = 1'b0;

   logic [7:0]  msgQ[$];
   logic [31:0] expQ0[$];
   logic [31:0] expQ1[$];

   bit          prevValid[2];
   bit          prevReady[2];
   logic [31:0] heldOut[2];

   crc_serial_engine #(
      .CRC_W(8), .DATA_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00)
   ) dut8 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(inReady8), .clr(clr),
      .crc_out(crcOut8), .crc_valid(crcValid8), .crc_ready(crc_ready),
      .busy(busy8)
   );

   crc_serial_engine #(
      .CRC_W(16), .DATA_W(8), .POLY(16'h1021), .INIT(16'hFFFF), .XOR_OUT(16'h0000)
   ) dut16 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(inReady16), .clr(clr),
      .crc_out(crcOut16), .crc_valid(crcValid16), .crc_ready(crc_ready),
      .busy(busy16)
   );

   // Free-running clock and a cycle counter for latency/spacing checks.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   // Textbook byte-at-a-time CRC, non-reflected, MSB first.
   function automatic logic [31:0] modelCrc(input int w, input logic [31:0] poly,
                                            input logic [31:0] init, input logic [31:0] xo,
                                            input logic [7:0] msg[$]);
      logic [31:0] mask;
      logic [31:0] c;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      c = init & mask;
      foreach (msg[i]) begin
         c = c ^ ({24'd0, msg[i]} << (w - 8));
         for (int b = 0; b < 8; b++) begin
            if (c[w-1]) c = ((c << 1) ^ poly) & mask;
            else        c = (c << 1) & mask;
         end
      end
      return (c ^ xo) & mask;
   endfunction

   task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic reportTimeout(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s: timed out, got no response, expected one", name);
   endtask

   // Monitor step for one instance: held-output stability, latency of the
   // first valid cycle, and scoreboard pop on the consumer handshake.
   task automatic checkOutput(input int id, input logic valid, input logic inRdy,
                              input logic bsy, input logic [31:0] out);
      logic [31:0] exp;
      string tag;
      tag = (id == 0) ? "crc8" : "crc16";
      if (valid) begin
         checkEq({tag, " in_ready while crc_valid"}, {31'd0, inRdy}, 32'd0);
         checkEq({tag, " busy while crc_valid"}, {31'd0, bsy}, 32'd1);
         if (prevValid[id] && !prevReady[id])
            checkEq({tag, " held crc_out"}, out, heldOut[id]);
         if (!prevValid[id])
            checkEq({tag, " crc_valid latency"}, cycle - lastHsNeg, 32'd9);
         if (crc_ready) begin
            if (id == 0) begin
               if (expQ0.size() == 0) begin
                  reportTimeout({tag, " unexpected result"});
               end else begin
                  exp = expQ0.pop_front();
                  checkEq({tag, " crc_out"}, out, exp);
               end
            end else begin
               if (expQ1.size() == 0) begin
                  reportTimeout({tag, " unexpected result"});
               end else begin
                  exp = expQ1.pop_front();
                  checkEq({tag, " crc_out"}, out, exp);
               end
            end
         end
      end
      prevValid[id] = valid;
      prevReady[id] = crc_ready;
      heldOut[id]   = out;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prevValid[0] = 1'b0;
         prevValid[1] = 1'b0;
      end else begin
         checkOutput(0, crcValid8, inReady8, busy8, {24'd0, crcOut8});
         checkOutput(1, crcValid16, inReady16, busy16, {16'd0, crcOut16});
      end
   end

   // Random consumer backpressure, changed just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randomReady) crc_ready = 1'($urandom_range(0, 1));
      end
   end

   // Offer one word and wait for the handshake; queue expected results on
   // the last word (known vector when given, reference model otherwise).
   task automatic applyStimulus(input logic [7:0] d, input logic l,
                                input bit k8v, input logic [31:0] k8,
                                input bit k16v, input logic [31:0] k16,
                                input bit chkSpacing);
      int guard;
      int hsc;
      @(negedge clk);
      in_data  = d;
      in_last  = l;
      in_valid = 1'b1;
      guard = 0;
      while (!(inReady8 && inReady16)) begin
         if (guard >= 300) begin
            reportTimeout("word handshake");
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
         guard++;
      end
      hsc = cycle;
      if (chkSpacing && prevHs >= 0)
         checkEq("word spacing", hsc - prevHs, 32'd9);
      prevHs = hsc;
      msgQ.push_back(d);
      if (l) begin
         expQ0.push_back(k8v  ? k8  : modelCrc(8,  32'h07,   32'h0,    32'h0, msgQ));
         expQ1.push_back(k16v ? k16 : modelCrc(16, 32'h1021, 32'hFFFF, 32'h0, msgQ));
         msgQ.delete();
         lastHsNeg = hsc;
      end
      @(posedge clk);
      #1;
      if (l) in_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int guard;
      guard = 0;
      @(negedge clk);
      while (busy8 || busy16) begin
         if (guard >= 500) begin
            reportTimeout("return to idle");
            return;
         end
         @(negedge clk);
         guard++;
      end
   endtask

   task automatic clrPulse();
      in_valid = 1'b0;
      waitIdle();
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 8'h55;
      in_last  = 1'b1;
      #1;
      checkEq("crc8 in_ready during clr", {31'd0, inReady8}, 32'd0);
      checkEq("crc16 in_ready during clr", {31'd0, inReady16}, 32'd0);
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      msgQ.delete();
      @(negedge clk);
      checkEq("crc8 busy after clr", {31'd0, busy8}, 32'd0);
      checkEq("crc16 busy after clr", {31'd0, busy16}, 32'd0);
   endtask

   initial begin
      int guard;
      int len;
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      crc_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      checkEq("crc8 reset in_ready", {31'd0, inReady8}, 32'd1);
      checkEq("crc8 reset crc_valid", {31'd0, crcValid8}, 32'd0);
      checkEq("crc8 reset busy", {31'd0, busy8}, 32'd0);
      checkEq("crc8 reset crc_out", {24'd0, crcOut8}, 32'h00);
      checkEq("crc16 reset in_ready", {31'd0, inReady16}, 32'd1);
      checkEq("crc16 reset crc_valid", {31'd0, crcValid16}, 32'd0);
      checkEq("crc16 reset crc_out", {16'd0, crcOut16}, 32'hFFFF);

      // Single word 0x01 and 0xFF with a held result
      $display("[TB] directed single words");
      applyStimulus(8'h01, 1'b1, 1'b1, 32'h07, 1'b0, 32'h0, 1'b0);
      waitIdle();
      @(posedge clk);
      #1 crc_ready = 1'b0;
      applyStimulus(8'hFF, 1'b1, 1'b1, 32'hF3, 1'b0, 32'h0, 1'b0);
      guard = 0;
      while (!crcValid8 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!crcValid8) reportTimeout("crc_valid for 0xFF");
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1 crc_ready = 1'b1;
      waitIdle();

      // "123456789" with in_valid held high, also the CRC-16 check value
      $display("[TB] check string 123456789");
      prevHs = -1;
      for (int i = 0; i < 9; i++)
         applyStimulus(8'(8'h31 + i), (i == 8), 1'b1, 32'hF4, 1'b1, 32'h29B1, 1'b1);
      waitIdle();

      // Reset during the fourth SHIFT cycle
      $display("[TB] reset mid-shift");
      prevHs = -1;
      applyStimulus(8'h31, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      msgQ.delete();
      @(negedge clk);
      checkEq("crc8 in_ready after mid reset", {31'd0, inReady8}, 32'd1);
      checkEq("crc8 crc_valid after mid reset", {31'd0, crcValid8}, 32'd0);
      checkEq("crc8 busy after mid reset", {31'd0, busy8}, 32'd0);
      checkEq("crc16 in_ready after mid reset", {31'd0, inReady16}, 32'd1);
      applyStimulus(8'h01, 1'b1, 1'b1, 32'h07, 1'b0, 32'h0, 1'b0);
      waitIdle();

      // Clear between words aborts the message
      $display("[TB] clr between words");
      applyStimulus(8'h31, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      clrPulse();
      applyStimulus(8'h01, 1'b1, 1'b1, 32'h07, 1'b0, 32'h0, 1'b0);
      waitIdle();

      // Random messages against the reference model
      $display("[TB] random messages");
      randomReady = 1'b1;
      for (int m = 0; m < 40; m++) begin
         len = $urandom_range(1, 4);
         for (int w = 0; w < len; w++) begin
            applyStimulus(8'($urandom), (w == len - 1), 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
            if (w != len - 1 && $urandom_range(0, 9) == 0) begin
               clrPulse();
               break;
            end
            if ($urandom_range(0, 2) == 0) begin
               in_valid = 1'b0;
               repeat ($urandom_range(1, 12)) @(negedge clk);
            end
         end
      end
      in_valid = 1'b0;

      guard = 0;
      while ((expQ0.size() != 0 || expQ1.size() != 0) && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      checkEq("crc8 scoreboard drained", expQ0.size(), 32'd0);
      checkEq("crc16 scoreboard drained", expQ1.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop so the bench can never hang.
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
